// File: rtl/darkbus_pkg.sv
// Shared types and helpers for the darkbus arbiter slice.
package darkbus_pkg;

  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_DONE} arb_state_t;

  localparam int MAX_PORTS = 8;

  // OR-reduction form: no priority chain, input is known to be one-hot.
  function automatic logic [2:0] onehot2idx(input logic [MAX_PORTS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/darkbus_rrpick.sv
// Combinational winner select: fixed priority (port 0 first) or round-robin after last_port.
module darkbus_rrpick
  import darkbus_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int LW    = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [LW-1:0]    last_port,
  input  arb_mode_t        mode,
  output logic [NPORT-1:0] win
);

  int idx;

  // Loops run from lowest priority to highest so the last hit is the winner.
  always_comb begin
    win = '0;
    idx = 0;
    if (mode == ARB_FIXED) begin
      for (int i = NPORT - 1; i >= 0; i--)
        if (req[i]) begin
          win    = '0;
          win[i] = 1'b1;
        end
    end else begin
      for (int i = NPORT; i >= 1; i--) begin
        idx = (int'(last_port) + i) % NPORT;
        if (req[idx]) begin
          win      = '0;
          win[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/darkbus_arbiter.sv
// N-port darkbus arbiter: one transaction at a time onto a single provider,
// with fixed or round-robin selection and a per-transaction timeout.
module darkbus_arbiter
  import darkbus_pkg::*;
#(
  parameter int NPORT   = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 15
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic [NPORT-1:0]             m_en,
  input  logic [NPORT-1:0]             m_rw,
  input  logic [NPORT-1:0][DW/8-1:0]   m_be,
  input  logic [NPORT-1:0][AW-1:0]     m_addr,
  input  logic [NPORT-1:0][DW-1:0]     m_wdata,
  output logic [NPORT-1:0][DW-1:0]     m_rdata,
  output logic [NPORT-1:0]             m_valid,
  output logic [NPORT-1:0]             m_err,
  output logic                         s_en,
  output logic                         s_rw,
  output logic [DW/8-1:0]              s_be,
  output logic [AW-1:0]                s_addr,
  output logic [DW-1:0]                s_wdata,
  input  logic [DW-1:0]                s_rdata,
  input  logic                         s_valid,
  output logic [NPORT-1:0]             grant,
  output logic                         busy
);

  localparam int        LW       = $clog2(NPORT);
  localparam int        CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit        TMO_EN   = (TIMEOUT > 0);
  localparam logic [CW-1:0] TLAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam arb_mode_t ARB_MODE = (MODE == 1) ? ARB_RR : ARB_FIXED;

  arb_state_t            state;
  logic [CW-1:0]         cnt;
  logic [LW-1:0]         last_port;
  logic [NPORT-1:0]      win;
  logic [MAX_PORTS-1:0]  grant_ext;
  logic [LW-1:0]         gidx;
  logic                  in_grant, req_g, tmo_hit, complete, timeout, finish;

  darkbus_rrpick #(.NPORT(NPORT), .LW(LW)) u_pick (
    .req       (m_en),
    .last_port (last_port),
    .mode      (ARB_MODE),
    .win       (win)
  );

  assign grant_ext = MAX_PORTS'(grant);
  assign gidx      = LW'(onehot2idx(grant_ext));
  assign in_grant  = (state == ARB_GRANT);
  assign req_g     = in_grant & m_en[gidx];
  // cnt counts completed no-answer cycles, so the T-th cycle sees cnt == T-1.
  assign tmo_hit   = TMO_EN && (cnt == TLAST);
  assign complete  = req_g & s_valid;
  assign timeout   = req_g & ~s_valid & tmo_hit;
  assign finish    = complete | timeout;

  assign s_en    = req_g & ~timeout;
  assign s_rw    = in_grant ? m_rw[gidx]    : 1'b0;
  assign s_be    = in_grant ? m_be[gidx]    : '0;
  assign s_addr  = in_grant ? m_addr[gidx]  : '0;
  assign s_wdata = in_grant ? m_wdata[gidx] : '0;
  assign m_valid = finish  ? grant : '0;
  assign m_err   = timeout ? grant : '0;
  assign busy    = (state != ARB_IDLE);

  always_comb begin
    m_rdata = '0;
    if (finish) m_rdata[gidx] = s_rdata;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      cnt       <= '0;
      last_port <= LW'(NPORT - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|m_en) begin
            grant <= win;
            cnt   <= '0;
            state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // A withdrawn request is an abort: no completion, no last_port update.
          if (!m_en[gidx]) begin
            grant <= '0;
            state <= ARB_IDLE;
          end else if (finish) begin
            grant     <= '0;
            last_port <= gidx;
            state     <= ARB_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_darkbus_arbiter.sv
// Bench: DUT A = 2-port fixed priority, DUT B = 4-port round-robin with TIMEOUT 4,
// both checked every cycle against a transaction-level model plus directed cases.
module tb_darkbus_arbiter;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       en[2], rw[2];
  logic [3:0][3:0]  be[2];
  logic [3:0][31:0] addr[2], wd[2];
  logic             sv[2];
  logic [31:0]      srd[2];

  logic [1:0][31:0] a_rdata;
  logic [1:0]       a_valid, a_err, a_grant;
  logic             a_sen, a_srw, a_busy;
  logic [3:0]       a_sbe;
  logic [31:0]      a_saddr, a_swd;
  logic [3:0][31:0] b_rdata;
  logic [3:0]       b_valid, b_err, b_grant;
  logic             b_sen, b_srw, b_busy;
  logic [3:0]       b_sbe;
  logic [31:0]      b_saddr, b_swd;

  darkbus_arbiter #(.NPORT(2), .AW(32), .DW(32), .MODE(0), .TIMEOUT(15)) u_a (
    .clk(clk), .res(res), .m_en(en[0][1:0]), .m_rw(rw[0][1:0]), .m_be(be[0][1:0]),
    .m_addr(addr[0][1:0]), .m_wdata(wd[0][1:0]), .m_rdata(a_rdata), .m_valid(a_valid),
    .m_err(a_err), .s_en(a_sen), .s_rw(a_srw), .s_be(a_sbe), .s_addr(a_saddr),
    .s_wdata(a_swd), .s_rdata(srd[0]), .s_valid(sv[0]), .grant(a_grant), .busy(a_busy));

  darkbus_arbiter #(.NPORT(4), .AW(32), .DW(32), .MODE(1), .TIMEOUT(4)) u_b (
    .clk(clk), .res(res), .m_en(en[1]), .m_rw(rw[1]), .m_be(be[1]),
    .m_addr(addr[1]), .m_wdata(wd[1]), .m_rdata(b_rdata), .m_valid(b_valid),
    .m_err(b_err), .s_en(b_sen), .s_rw(b_srw), .s_be(b_sbe), .s_addr(b_saddr),
    .s_wdata(b_swd), .s_rdata(srd[1]), .s_valid(sv[1]), .grant(b_grant), .busy(b_busy));

  // Uniform 4-port view of both DUTs
  logic [3:0]   o_valid[2], o_err[2], o_grant[2], o_sbe[2];
  logic [127:0] o_rdata[2];
  logic         o_sen[2], o_srw[2], o_busy[2];
  logic [31:0]  o_saddr[2], o_swd[2];
  assign o_valid[0] = {2'b00, a_valid};  assign o_valid[1] = b_valid;
  assign o_err[0]   = {2'b00, a_err};    assign o_err[1]   = b_err;
  assign o_grant[0] = {2'b00, a_grant};  assign o_grant[1] = b_grant;
  assign o_rdata[0] = {64'd0, a_rdata};  assign o_rdata[1] = b_rdata;
  assign o_sen[0] = a_sen;   assign o_sen[1] = b_sen;
  assign o_srw[0] = a_srw;   assign o_srw[1] = b_srw;
  assign o_busy[0] = a_busy; assign o_busy[1] = b_busy;
  assign o_sbe[0] = a_sbe;   assign o_sbe[1] = b_sbe;
  assign o_saddr[0] = a_saddr; assign o_saddr[1] = b_saddr;
  assign o_swd[0] = a_swd;     assign o_swd[1] = b_swd;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner = port holding the bus (-1 none), age = grant cycles so far,
  // cool = post-completion settle cycle pending, last = most recent finisher.
  int m_owner[2] = '{-1, -1};
  int m_age[2]   = '{0, 0};
  int m_cool[2]  = '{0, 0};
  int m_last[2]  = '{1, 3};
  logic [3:0] pv[2];

  logic [3:0]   e_g, e_v, e_e, e_be;
  logic [127:0] e_rd;
  logic         e_sen, e_rw, e_busy, act, hit, dn;
  logic [31:0]  e_a, e_w;
  int           g, np, tm, pp;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      np = (d == 0) ? 2 : 4;
      tm = (d == 0) ? 15 : 4;
      e_g = '0; e_v = '0; e_e = '0; e_be = '0; e_rd = '0;
      e_sen = 1'b0; e_rw = 1'b0; e_busy = 1'b0; e_a = '0; e_w = '0;
      if (res) begin
        m_owner[d] = -1; m_age[d] = 0; m_cool[d] = 0; m_last[d] = np - 1;
      end else if (m_owner[d] >= 0) begin
        g = m_owner[d];
        e_g[g] = 1'b1; e_busy = 1'b1;
        act = en[d][g];
        hit = (m_age[d] + 1 == tm);
        dn  = act && (sv[d] || hit);
        e_v[g] = dn;
        e_e[g] = act && !sv[d] && hit;
        if (dn) e_rd[g*32 +: 32] = srd[d];
        e_sen = act && !(hit && !sv[d]);
        e_rw = rw[d][g]; e_be = be[d][g]; e_a = addr[d][g]; e_w = wd[d][g];
        if (!act) m_owner[d] = -1;
        else if (dn) begin m_last[d] = g; m_owner[d] = -1; m_cool[d] = 1; end
        else m_age[d]++;
      end else if (m_cool[d] > 0) begin
        e_busy = 1'b1;
        m_cool[d] = 0;
      end else begin
        for (int i = 1; i <= np; i++) begin
          pp = (d == 0) ? i - 1 : (m_last[d] + i) % np;
          if (en[d][pp]) begin m_owner[d] = pp; m_age[d] = 0; break; end
        end
      end
      pv[d] = e_v;
      chk($sformatf("d%0d grant", d), o_grant[d], e_g);
      chk($sformatf("d%0d busy", d), o_busy[d], e_busy);
      chk($sformatf("d%0d m_valid", d), o_valid[d], e_v);
      chk($sformatf("d%0d m_err", d), o_err[d], e_e);
      chk($sformatf("d%0d m_rdata", d), o_rdata[d], e_rd);
      chk($sformatf("d%0d s_en", d), o_sen[d], e_sen);
      chk($sformatf("d%0d s_bus", d), {o_srw[d], o_sbe[d], o_saddr[d], o_swd[d]},
          {e_rw, e_be, e_a, e_w});
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic rnd_cycle();
    cyc();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < ((d == 0) ? 2 : 4); p++) begin
        if (en[d][p]) begin
          if (pv[d][p] && ($urandom % 2 == 0)) en[d][p] = 1'b0;
          else if (o_grant[d][p] && !pv[d][p] && ($urandom % 24 == 0)) en[d][p] = 1'b0;
        end else if ($urandom % 4 == 0) begin
          en[d][p] = 1'b1; rw[d][p] = 1'($urandom); be[d][p] = 4'($urandom);
          addr[d][p] = $urandom; wd[d][p] = $urandom;
        end
      end
      srd[d] = $urandom;
      if (o_grant[d] == 4'b0) sv[d] = ($urandom % 8 == 0);
      else if ((o_grant[d] & en[d]) != 4'b0) sv[d] = ($urandom % 3 == 0);
      else sv[d] = 1'b0;
    end
  endtask

  int vt[4];
  int nv, gc, seq[5], ns;
  logic starve, got;
  logic [3:0] prevg;
  int exp_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int d = 0; d < 2; d++) begin
      en[d] = '0; rw[d] = '0; be[d] = '0; addr[d] = '0; wd[d] = '0; sv[d] = 1'b0; srd[d] = '0;
    end
    res = 1'b1;
    repeat (2) smp();
    chk("reset grant", {o_grant[1], o_grant[0]}, 8'h00);
    chk("reset busy/s_en", {o_busy[1], o_busy[0], o_sen[1], o_sen[0]}, 4'h0);
    chk("reset valid", {o_valid[1], o_valid[0]}, 8'h00);
    cyc(); res = 1'b0;

    // Fixed priority starvation: provider answers 2 cycles after s_en
    en[0][1:0] = 2'b11; nv = 0; gc = 0; starve = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      gc = (o_grant[0] != 4'b0) ? gc + 1 : 0;
      sv[0] = (gc == 3);
      smp();
      if (o_valid[0][0] && nv < 4) begin vt[nv] = i; nv++; end
      if (o_valid[0][1] || o_grant[0][1]) starve = 1'b1;
    end
    chk("fixed completions", nv, 4);
    chk("fixed port1 starved", starve, 1'b0);
    chk("fixed first valid", vt[0], 2);
    for (int k = 1; k < 4; k++) chk("fixed spacing", vt[k] - vt[k-1], 5);
    cyc(); en[0] = '0; sv[0] = 1'b0;
    repeat (4) cyc();

    // Round-robin order with everyone requesting
    en[1] = 4'b1111; ns = 0; prevg = '0;
    for (int i = 0; i < 40 && ns < 5; i++) begin
      cyc();
      sv[1] = (o_grant[1] != 4'b0);
      if (o_grant[1] != 4'b0 && prevg == 4'b0) begin
        for (int p = 0; p < 4; p++) if (o_grant[1][p]) seq[ns] = p;
        ns++;
      end
      prevg = o_grant[1];
      smp();
    end
    chk("rr grant count", ns, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("rr grant %0d", k), seq[k], exp_seq[k]);
    cyc(); en[1] = '0; sv[1] = 1'b0;
    repeat (3) cyc();

    // Read on port 1 of the fixed-priority DUT
    en[0][1] = 1'b1; rw[0][1] = 1'b0; addr[0][1] = 32'h0000_0040; srd[0] = 32'hDEAD_BEEF;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (o_grant[0] == 4'b0010) begin got = 1'b1; break; end
    end
    chk("read granted", got, 1'b1);
    sv[0] = 1'b1;
    smp();
    chk("read m_valid", o_valid[0], 4'b0010);
    chk("read m_rdata[1]", o_rdata[0][63:32], 32'hDEAD_BEEF);
    chk("read m_rdata[0]", o_rdata[0][31:0], 32'h0);
    chk("read s_addr", o_saddr[0], 32'h40);
    cyc(); en[0] = '0; sv[0] = 1'b0;
    repeat (3) cyc();

    // Timeout, then timeout coincident with s_valid
    for (int t = 0; t < 2; t++) begin
      en[1] = 4'b0001; got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        cyc();
        if (o_grant[1] == 4'b0001) begin got = 1'b1; break; end
      end
      chk("tmo granted", got, 1'b1);
      for (int n = 1; n <= 4; n++) begin
        if (n > 1) cyc();
        sv[1] = (t == 1) && (n == 4);
        smp();
        if (n < 4) begin
          chk("tmo early s_en", o_sen[1], 1'b1);
          chk("tmo early valid", o_valid[1], 4'b0000);
        end else if (t == 0) begin
          chk("tmo valid", o_valid[1], 4'b0001);
          chk("tmo err", o_err[1], 4'b0001);
          chk("tmo s_en", o_sen[1], 1'b0);
        end else begin
          chk("coincident valid", o_valid[1], 4'b0001);
          chk("coincident err", o_err[1], 4'b0000);
        end
      end
      cyc(); en[1] = '0; sv[1] = 1'b0;
      smp();
      chk("after tmo DONE", {o_busy[1], o_grant[1]}, 5'b10000);
      cyc(); smp();
      chk("after tmo IDLE", o_busy[1], 1'b0);
      cyc();
    end

    // Async reset mid-grant; last_port is 0 here so the pre-reset pick is port 1
    addr[1][1] = 32'h1234_5678; en[1] = 4'b1111; got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (o_grant[1] != 4'b0) begin got = 1'b1; break; end
    end
    chk("pre-reset grant", o_grant[1], 4'b0010);
    #2 res = 1'b1;
    #1;
    chk("async rst grant", o_grant[1], 4'b0000);
    chk("async rst outs", {o_busy[1], o_sen[1], o_valid[1], o_saddr[1]}, 38'h0);
    en[1] = '0;
    smp();
    cyc(); res = 1'b0; en[1] = 4'b1111; got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (o_grant[1] != 4'b0) begin got = 1'b1; break; end
    end
    chk("post-reset rr grant", o_grant[1], 4'b0001);
    en[1] = '0;
    repeat (3) cyc();

    repeat (3000) rnd_cycle();
    for (int d = 0; d < 2; d++) begin en[d] = '0; sv[d] = 1'b0; end
    repeat (5) cyc();
    smp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
